sram_1rw_port_arb: RTL and testbench

SRAM_1RW_PORT_ARB -- requirements
Module: sram_1rw_port_arb

---
 rtl/sram_1rw_port_arb.sv | 134 +++++++++++++
 tb/tb_sram_1rw_port_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_port_arb.sv
// 1W1R client front end for a single-port 1RW SRAM macro, with an in-order write buffer.
// Define SRAM_ARB_FWD_EN to forward buffered write data to reads instead of stalling them.
module sram_1rw_port_arb #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 64,
    parameter int WB_DEPTH = 2
) (
    input  logic              clk0,
    input  logic              rst0,
    input  logic              W0_en,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [DATA_W-1:0] W0_data,
    output logic              W0_ready,
    input  logic              R0_en,
    input  logic [ADDR_W-1:0] R0_addr,
    output logic              R0_ready,
    output logic              R0_valid,
    output logic [DATA_W-1:0] R0_data,
    output logic              mem_csb0,
    output logic              mem_web0,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [DATA_W-1:0] mem_din0,
    input  logic [DATA_W-1:0] mem_dout0
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]   wb_addr [WB_DEPTH];
    logic [DATA_W-1:0]   wb_data [WB_DEPTH];
    logic [WB_DEPTH-1:0] wb_vld;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;
    logic                push;
    logic                drain;
    logic                rd_acc;
    logic                rd_hit;

`ifdef SRAM_ARB_FWD_EN
    logic [DATA_W-1:0]   rd_hit_data;
    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;
`endif

    assign full  = (count == CNT_W'(WB_DEPTH));
    assign empty = (count == '0);

    // Scan oldest to youngest so the last match found is the youngest entry.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = head;
        rd_hit = 1'b0;
`ifdef SRAM_ARB_FWD_EN
        rd_hit_data = '0;
`endif
        for (int k = 0; k < WB_DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (wb_vld[idx] && (wb_addr[idx] == R0_addr)) begin
                rd_hit = 1'b1;
`ifdef SRAM_ARB_FWD_EN
                rd_hit_data = wb_data[idx];
`endif
            end
        end
    end

    // Handshake: a request transfers on a rising clk0 edge where en & ready are both high;
    // ready depends only on buffer state and R0_addr, never on the same port's en.
    assign W0_ready = ~full;
`ifdef SRAM_ARB_FWD_EN
    assign R0_ready = ~full;
`else
    assign R0_ready = ~full & ~rd_hit;
`endif

    assign push   = W0_en & W0_ready & ~rst0;
    assign rd_acc = R0_en & R0_ready & ~rst0;
    assign drain  = ~rst0 & (full | (~rd_acc & ~empty));

    assign mem_csb0  = ~(rd_acc | drain);
    assign mem_web0  = ~drain;
    assign mem_addr0 = drain ? wb_addr[head] : R0_addr;
    assign mem_din0  = wb_data[head];

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wb_vld   <= '0;
            R0_valid <= 1'b0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr[i] <= '0;
                wb_data[i] <= '0;
            end
        end else begin
            if (drain) begin
                wb_vld[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            if (push) begin
                wb_vld[tail]  <= 1'b1;
                wb_addr[tail] <= W0_addr;
                wb_data[tail] <= W0_data;
                tail          <= tail + 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            R0_valid <= rd_acc;
        end
    end

`ifdef SRAM_ARB_FWD_EN
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else if (rd_acc) begin
            fwd_hit  <= rd_hit;
            fwd_data <= rd_hit_data;
        end
    end

    assign R0_data = fwd_hit ? fwd_data : mem_dout0;
`else
    assign R0_data = mem_dout0;
`endif

endmodule

// File: tb/tb_sram_1rw_port_arb.sv
// Bench for sram_1rw_port_arb: behavioural SRAM macro, coherent-memory reference model
// and a negedge monitor that checks handshakes, macro operations and read data.
module tb_sram_1rw_port_arb;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 64;
    localparam int WB_DEPTH = 2;
    localparam int MEM_N    = 1 << ADDR_W;
`ifdef SRAM_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk0;
    logic              rst0;
    logic              W0_en;
    logic [ADDR_W-1:0] W0_addr;
    logic [DATA_W-1:0] W0_data;
    logic              W0_ready;
    logic              R0_en;
    logic [ADDR_W-1:0] R0_addr;
    logic              R0_ready;
    logic              R0_valid;
    logic [DATA_W-1:0] R0_data;
    logic              mem_csb0;
    logic              mem_web0;
    logic [ADDR_W-1:0] mem_addr0;
    logic [DATA_W-1:0] mem_din0;
    logic [DATA_W-1:0] mem_dout0;

    sram_1rw_port_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(WB_DEPTH)
    ) dut (
        .clk0(clk0), .rst0(rst0),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_ready(W0_ready),
        .R0_en(R0_en), .R0_addr(R0_addr), .R0_ready(R0_ready),
        .R0_valid(R0_valid), .R0_data(R0_data),
        .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
        .mem_din0(mem_din0), .mem_dout0(mem_dout0)
    );

    // ---------------- clock ----------------
    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // ---------------- counters and check helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chka(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural 1RW macro ----------------
    logic [DATA_W-1:0] sram [MEM_N];

    initial begin
        for (int i = 0; i < MEM_N; i++) sram[i] = {$urandom(), $urandom()};
        mem_dout0 = '0;
        forever begin
            @(posedge clk0);
            if (!mem_csb0 && !mem_web0) sram[mem_addr0] <= mem_din0;
            if (!mem_csb0 && mem_web0) mem_dout0 <= sram[mem_addr0];
            else mem_dout0 <= {$urandom(), $urandom()};
        end
    end

    // ---------------- reference model + scoreboard ----------------
    // ref_mem is what a coherent memory holds after every accepted write;
    // wq is the set of accepted writes not yet committed to the macro, oldest first.
    logic [DATA_W-1:0] ref_mem [MEM_N];
    logic [ADDR_W-1:0] wq_addr[$];
    logic [DATA_W-1:0] wq_data[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_valid = 1'b0;

    initial begin
        bit full;
        bit hit;
        bit exp_wr;
        bit exp_rr;
        bit r_acc;
        bit w_acc;
        bit do_drain;
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk0);
            if (rst0) begin
                chk1("rst_csb", mem_csb0, 1'b1);
                chk1("rst_web", mem_web0, 1'b1);
                chk1("rst_r0_valid", R0_valid, 1'b0);
                chk1("rst_w0_ready", W0_ready, 1'b1);
                chk1("rst_r0_ready", R0_ready, 1'b1);
                wq_addr.delete();
                wq_data.delete();
                exp_q.delete();
                exp_valid = 1'b0;
                for (int i = 0; i < MEM_N; i++) ref_mem[i] = sram[i];
            end else begin
                chk1("r0_valid", R0_valid, exp_valid);
                if (R0_valid && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chkd("r0_data", R0_data, e);
                end

                full = (wq_addr.size() == WB_DEPTH);
                hit  = 1'b0;
                foreach (wq_addr[i]) if (wq_addr[i] == R0_addr) hit = 1'b1;
                exp_wr = !full;
                exp_rr = !full && (FWD || !hit);
                chk1("w0_ready", W0_ready, exp_wr);
                chk1("r0_ready", R0_ready, exp_rr);

                r_acc    = R0_en && exp_rr;
                w_acc    = W0_en && exp_wr;
                do_drain = full || (!r_acc && wq_addr.size() > 0);
                chk1("mem_csb0", mem_csb0, !(r_acc || do_drain));
                chk1("mem_web0", mem_web0, !do_drain);
                if (do_drain) begin
                    chka("drain_addr", mem_addr0, wq_addr[0]);
                    chkd("drain_data", mem_din0, wq_data[0]);
                    void'(wq_addr.pop_front());
                    void'(wq_data.pop_front());
                end else if (r_acc) begin
                    chka("read_addr", mem_addr0, R0_addr);
                end

                // Read sees contents before this cycle's write.
                if (r_acc) exp_q.push_back(ref_mem[R0_addr]);
                exp_valid = r_acc;
                if (w_acc) begin
                    wq_addr.push_back(W0_addr);
                    wq_data.push_back(W0_data);
                    ref_mem[W0_addr] = W0_data;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        W0_en = 1'b0;
        R0_en = 1'b0;
        repeat (n) begin
            @(posedge clk0);
            #1;
        end
    endtask

    task automatic drive(input bit we, input int wa, input logic [DATA_W-1:0] wd,
                         input bit re, input int ra);
        W0_en   = we;
        W0_addr = ADDR_W'(wa);
        W0_data = wd;
        R0_en   = re;
        R0_addr = ADDR_W'(ra);
        @(posedge clk0);
        #1;
    endtask

    // Holds each request until it is accepted, bounded at 16 cycles.
    task automatic op(input bit we, input int wa, input logic [DATA_W-1:0] wd,
                      input bit re, input int ra);
        bit wp;
        bit rp;
        int n;
        wp = we;
        rp = re;
        n  = 0;
        while ((wp || rp) && n < 16) begin
            W0_en   = wp;
            W0_addr = ADDR_W'(wa);
            W0_data = wd;
            R0_en   = rp;
            R0_addr = ADDR_W'(ra);
            @(negedge clk0);
            if (W0_ready) wp = 1'b0;
            if (R0_ready) rp = 1'b0;
            @(posedge clk0);
            #1;
            n++;
        end
        chk1("op_timeout", wp || rp, 1'b0);
        W0_en = 1'b0;
        R0_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst0 = 1'b1;
        repeat (n) @(posedge clk0);
        #1;
        rst0 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst0    = 1'b1;
        W0_en   = 1'b0;
        W0_addr = '0;
        W0_data = '0;
        R0_en   = 1'b0;
        R0_addr = '0;
        repeat (3) @(posedge clk0);
        #1;
        rst0 = 1'b0;
        idle(3);

        // Write then read the same address on the next cycle.
        op(1'b1, 5, 64'hAA, 1'b0, 0);
        op(1'b0, 0, '0, 1'b1, 5);
        idle(3);

        // Two writes to one address, then a read of it: youngest value wins.
        op(1'b1, 3, 64'h1, 1'b1, 10);
        op(1'b1, 3, 64'h2, 1'b1, 11);
        op(1'b0, 0, '0, 1'b1, 3);
        idle(3);

        // Fill the buffer under continuous reads, then read both addresses back.
        op(1'b1, 20, 64'h2020, 1'b1, 30);
        op(1'b1, 21, 64'h2121, 1'b1, 31);
        for (int i = 0; i < 4; i++) op(1'b0, 0, '0, 1'b1, 32 + i);
        op(1'b0, 0, '0, 1'b1, 20);
        op(1'b0, 0, '0, 1'b1, 21);
        idle(2);

        // Same-cycle write and read of one address returns the old contents.
        op(1'b1, 7, 64'h7777, 1'b1, 7);
        op(1'b0, 0, '0, 1'b1, 7);
        idle(3);

        // Reset with two buffered writes and a read response in flight.
        op(1'b1, 40, 64'h4040, 1'b1, 41);
        op(1'b1, 42, 64'h4242, 1'b1, 43);
        do_reset(2);
        idle(3);
        op(1'b0, 0, '0, 1'b1, 40);
        op(1'b0, 0, '0, 1'b1, 42);
        idle(2);

        // Randomized traffic over a small address window to force collisions.
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset($urandom_range(1, 3));
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 15), {$urandom(), $urandom()},
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15));
        end
        idle(4);
        for (int a = 0; a < 16; a++) op(1'b0, 0, '0, 1'b1, a);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
